// File: rtl/video_cmd_unit.sv
// ============================================================================
// Module   : video_cmd_unit
// Purpose  : Video page command engine (select / fill / copy / blit) for a
//            4-page, 4bpp VRAM with 1-cycle read latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_cmd_unit #(
  parameter int WORDS = 16000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_arg0,
  input  logic [7:0]  cmd_arg1,
  output logic [15:0] vram_raddr,
  output logic        vram_re,
  input  logic [15:0] vram_rdata,
  output logic [15:0] vram_waddr,
  output logic [15:0] vram_wdata,
  output logic        vram_we,
  output logic [1:0]  work_page,
  output logic [1:0]  front_page,
  output logic [1:0]  back_page,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_fill  = 2'd1;
  localparam logic [1:0] c_copy  = 2'd2;
  localparam logic [1:0] c_drain = 2'd3;

  localparam logic [1:0] c_op_select = 2'd0;
  localparam logic [1:0] c_op_fill   = 2'd1;
  localparam logic [1:0] c_op_copy   = 2'd2;

  localparam logic [13:0] c_last = 14'(WORDS - 1);

  logic [1:0]  r_state;
  logic [13:0] r_cnt;
  logic [13:0] r_wcnt;
  logic        r_wr_pend;
  logic [1:0]  r_src;
  logic [1:0]  r_dst;
  logic [3:0]  r_color;
  logic [1:0]  r_work;
  logic [1:0]  r_front;
  logic [1:0]  r_back;
  logic        r_done;

  logic        w_ready;
  logic        w_accept;
  logic [1:0]  w_sel0;
  logic [1:0]  w_sel1;

  function automatic logic [1:0] resolve(input logic [7:0] sel,
                                         input logic [1:0] front,
                                         input logic [1:0] back);
    if (sel == 8'hFE)      return front;
    else if (sel == 8'hFF) return back;
    else                   return sel[1:0];
  endfunction

  assign w_ready  = (r_state == c_idle);
  assign w_accept = cmd_valid && w_ready;
  assign w_sel0   = resolve(cmd_arg0, r_front, r_back);
  assign w_sel1   = resolve(cmd_arg1, r_front, r_back);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= c_idle;
      r_cnt     <= 14'd0;
      r_wcnt    <= 14'd0;
      r_wr_pend <= 1'b0;
      r_src     <= 2'd0;
      r_dst     <= 2'd0;
      r_color   <= 4'd0;
      r_work    <= 2'd2;
      r_front   <= 2'd2;
      r_back    <= 2'd1;
      r_done    <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      // Write side of a copy trails the read side by one cycle.
      r_wr_pend <= (r_state == c_copy);
      r_wcnt    <= r_cnt;
      case (r_state)
        c_idle: begin
          if (w_accept) begin
            case (cmd_op)
              c_op_select: begin
                r_work <= w_sel0;
                r_done <= 1'b1;
              end
              c_op_fill: begin
                r_src   <= w_sel0;
                r_color <= cmd_arg1[3:0];
                r_cnt   <= 14'd0;
                r_state <= c_fill;
              end
              c_op_copy: begin
                r_src   <= w_sel0;
                r_dst   <= w_sel1;
                r_cnt   <= 14'd0;
                r_state <= c_copy;
              end
              default: begin
                if (cmd_arg0 == 8'hFF) begin
                  r_front <= r_back;
                  r_back  <= r_front;
                end else if (cmd_arg0 != 8'hFE) begin
                  r_front <= cmd_arg0[1:0];
                end
                r_done <= 1'b1;
              end
            endcase
          end
        end
        c_fill: begin
          if (r_cnt == c_last) begin
            r_state <= c_idle;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 14'd1;
          end
        end
        c_copy: begin
          // Counter parks on the last word so the drain write reuses it.
          if (r_cnt == c_last) begin
            r_state <= c_drain;
          end else begin
            r_cnt <= r_cnt + 14'd1;
          end
        end
        default: begin
          r_state <= c_idle;
          r_done  <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    vram_re    = 1'b0;
    vram_raddr = 16'd0;
    vram_we    = 1'b0;
    vram_waddr = 16'd0;
    vram_wdata = 16'd0;
    case (r_state)
      c_fill: begin
        vram_we    = 1'b1;
        vram_waddr = {r_src, r_cnt};
        vram_wdata = {4{r_color}};
      end
      c_copy: begin
        vram_re    = 1'b1;
        vram_raddr = {r_src, r_cnt};
        vram_we    = r_wr_pend;
        vram_waddr = {r_dst, r_wcnt};
        vram_wdata = vram_rdata;
      end
      c_drain: begin
        vram_we    = 1'b1;
        vram_waddr = {r_dst, r_wcnt};
        vram_wdata = vram_rdata;
      end
      default: begin
        vram_re = 1'b0;
      end
    endcase
  end

  assign cmd_ready  = w_ready;
  assign busy       = (r_state != c_idle);
  assign done       = r_done;
  assign work_page  = r_work;
  assign front_page = r_front;
  assign back_page  = r_back;

endmodule

`default_nettype wire

// File: tb/tb_video_cmd_unit.sv
// ============================================================================
// Module   : tb_video_cmd_unit
// Purpose  : Randomized self-checking bench for video_cmd_unit (WORDS=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_video_cmd_unit;

  localparam int WORDS = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_arg0;
  logic [7:0]  cmd_arg1;
  logic [15:0] vram_raddr;
  logic        vram_re;
  logic [15:0] vram_rdata;
  logic [15:0] vram_waddr;
  logic [15:0] vram_wdata;
  logic        vram_we;
  logic [1:0]  work_page;
  logic [1:0]  front_page;
  logic [1:0]  back_page;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_bad = 0;

  logic [1:0] m_work, m_front, m_back;

  video_cmd_unit #(.WORDS(WORDS)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_arg0   (cmd_arg0),
    .cmd_arg1   (cmd_arg1),
    .vram_raddr (vram_raddr),
    .vram_re    (vram_re),
    .vram_rdata (vram_rdata),
    .vram_waddr (vram_waddr),
    .vram_wdata (vram_wdata),
    .vram_we    (vram_we),
    .work_page  (work_page),
    .front_page (front_page),
    .back_page  (back_page),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // VRAM content is a fixed scramble of the address, returned one cycle after the read.
  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return a ^ 16'h3C5A;
  endfunction

  always @(posedge clk) begin
    if (vram_re) vram_rdata <= mem_val(vram_raddr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] res(input logic [7:0] s);
    if (s == 8'hFE)      return m_front;
    else if (s == 8'hFF) return m_back;
    else                 return s[1:0];
  endfunction

  function automatic logic [7:0] pick_sel();
    case ($urandom_range(0, 3))
      0:       return 8'hFE;
      1:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic check_pages();
    check("work_page",  32'(work_page),  32'(m_work));
    check("front_page", 32'(front_page), 32'(m_front));
    check("back_page",  32'(back_page),  32'(m_back));
  endtask

  task automatic check_quiet(input bit exp_done);
    check("idle_busy", 32'(busy),      32'(0));
    check("idle_we",   32'(vram_we),   32'(0));
    check("idle_re",   32'(vram_re),   32'(0));
    check("idle_rdy",  32'(cmd_ready), 32'(1));
    check("idle_done", 32'(done),      32'(exp_done));
  endtask

  task automatic check_reset_state();
    check("rst_busy",  32'(busy),       32'(0));
    check("rst_done",  32'(done),       32'(0));
    check("rst_we",    32'(vram_we),    32'(0));
    check("rst_re",    32'(vram_re),    32'(0));
    check("rst_raddr", 32'(vram_raddr), 32'(0));
    check("rst_waddr", 32'(vram_waddr), 32'(0));
    check("rst_wdata", 32'(vram_wdata), 32'(0));
    check("rst_work",  32'(work_page),  32'(2));
    check("rst_front", 32'(front_page), 32'(2));
    check("rst_back",  32'(back_page),  32'(1));
  endtask

  task automatic model_reset();
    m_work = 2'd2; m_front = 2'd2; m_back = 2'd1;
  endtask

  // Entered just after a falling edge with the unit idle; returns at the
  // falling edge of the cycle in which done is expected.
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] a0,
                        input logic [7:0] a1, input bit hold);
    logic [1:0] p, d, tmp;
    logic [3:0] c;
    check("ready", 32'(cmd_ready), 32'(1));
    cmd_valid = 1'b1; cmd_op = op; cmd_arg0 = a0; cmd_arg1 = a1;
    p = res(a0); d = res(a1); c = a1[3:0];
    if (op == 2'd0) m_work = p;
    if (op == 2'd3) begin
      if (a0 == 8'hFF) begin tmp = m_front; m_front = m_back; m_back = tmp; end
      else if (a0 != 8'hFE) m_front = a0[1:0];
    end
    @(negedge clk);
    if (hold) begin cmd_op = 2'd0; cmd_arg0 = 8'h00; end
    else cmd_valid = 1'b0;
    if (op == 2'd1) begin
      for (int i = 0; i < WORDS; i++) begin
        check("fill_busy",  32'(busy),       32'(1));
        check("fill_rdy",   32'(cmd_ready),  32'(0));
        check("fill_done",  32'(done),       32'(0));
        check("fill_we",    32'(vram_we),    32'(1));
        check("fill_re",    32'(vram_re),    32'(0));
        check("fill_waddr", 32'(vram_waddr), 32'({p, 14'(i)}));
        check("fill_wdata", 32'(vram_wdata), 32'({4{c}}));
        check_pages();
        @(negedge clk);
      end
    end else if (op == 2'd2) begin
      for (int k = 0; k <= WORDS; k++) begin
        check("copy_busy", 32'(busy),      32'(1));
        check("copy_rdy",  32'(cmd_ready), 32'(0));
        check("copy_done", 32'(done),      32'(0));
        check("copy_re",   32'(vram_re),   32'(k < WORDS));
        if (k < WORDS) check("copy_raddr", 32'(vram_raddr), 32'({p, 14'(k)}));
        check("copy_we",   32'(vram_we),   32'(k > 0));
        if (k > 0) begin
          check("copy_waddr", 32'(vram_waddr), 32'({d, 14'(k - 1)}));
          check("copy_wdata", 32'(vram_wdata), 32'(mem_val({p, 14'(k - 1)})));
        end
        @(negedge clk);
      end
    end
    check("done_pulse", 32'(done), 32'(1));
    check("done_busy",  32'(busy), 32'(0));
    check("done_we",    32'(vram_we), 32'(0));
    check_pages();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check_reset_state();
    @(negedge clk);
    check_reset_state();
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg0 = 8'd0; cmd_arg1 = 8'd0;
    vram_rdata = 16'd0;
    model_reset();
    repeat (2) @(negedge clk);
    apply_reset();

    // Page register behaviour after reset, back to back with done/accept overlap.
    do_cmd(2'd3, 8'hFF, 8'h00, 1'b0);
    check("blit_swap_front", 32'(front_page), 32'(1));
    check("blit_swap_back",  32'(back_page),  32'(2));
    do_cmd(2'd3, 8'hFE, 8'h00, 1'b0);
    do_cmd(2'd3, 8'h03, 8'h00, 1'b0);
    check("blit_front3", 32'(front_page), 32'(3));
    do_cmd(2'd0, 8'hFE, 8'h00, 1'b0);
    check("select_work3", 32'(work_page), 32'(3));

    do_cmd(2'd1, 8'h01, 8'h05, 1'b0);
    do_cmd(2'd2, 8'h00, 8'h03, 1'b0);
    do_cmd(2'd2, 8'h02, 8'h02, 1'b0);

    // Command held valid through a fill must wait for the done cycle.
    apply_reset();
    do_cmd(2'd1, 8'hFF, 8'h0C, 1'b1);
    check("held_rdy", 32'(cmd_ready), 32'(1));
    m_work = 2'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("held_done", 32'(done), 32'(1));
    check_pages();

    // Reset pulse in the middle of a fill.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_arg0 = 8'h02; cmd_arg1 = 8'h0A;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_fill_we", 32'(vram_we), 32'(1));
    check("mid_fill_waddr", 32'(vram_waddr), 32'(16'h8003));
    apply_reset();
    repeat (WORDS) begin
      @(negedge clk);
      check_quiet(1'b0);
    end

    // Randomized command stream against the page model.
    for (int t = 0; t < 60; t++) begin
      logic [1:0] op;
      logic [7:0] a0, a1;
      op = 2'($urandom_range(0, 3));
      a0 = pick_sel();
      a1 = (op == 2'd1) ? 8'($urandom) : pick_sel();
      do_cmd(op, a0, a1, 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check_quiet(1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/video_cmd_unit.md
VIDEO_CMD_UNIT -- requirements
Module: video_cmd_unit

Interface
REQ-001 SHALL have parameter: WORDS, 16000, number of 16-bit words per video page (320x200 pixels at 4bpp, 4 pixels per word).
REQ-002 SHALL have port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: cmd_valid  input  1  command from the VM CPU is present.
REQ-005 SHALL have port: cmd_ready  output  1  block accepts a command this cycle.
REQ-006 SHALL have port: cmd_op  input  2  0=selectVideoPage, 1=fillVideoPage, 2=copyVideoPage, 3=blitFrameBuffer.
REQ-007 SHALL have port: cmd_arg0  input  8  page selector (select, fill, blit); source page (copy).
REQ-008 SHALL have port: cmd_arg1  input  8  fill colour in bits [3:0] (fill); destination page selector (copy).
REQ-009 SHALL have port: vram_raddr  output  16  read address {page[1:0], word[13:0]}.
REQ-010 SHALL have port: vram_re  output  1  read strobe; vram_rdata is valid exactly one cycle later.
REQ-011 SHALL have port: vram_rdata  input  16  read data.
REQ-012 SHALL have port: vram_waddr  output  16  write address {page[1:0], word[13:0]}.
REQ-013 SHALL have port: vram_wdata  output  16  write data.
REQ-014 SHALL have port: vram_we  output  1  write strobe.
REQ-015 SHALL have ports: work_page, front_page, back_page  output  2 each  current page registers; front_page is the displayed page.
REQ-016 SHALL have port: busy  output  1  fill or copy in progress.
REQ-017 SHALL have port: done  output  1  one-cycle pulse when a command completes.

Function
REQ-018 Page resolution SHALL be: selector 0xFE -> front_page; 0xFF -> back_page; any other value -> selector[1:0]. Selectors are resolved at the accept edge.
REQ-019 cmd_ready SHALL be 1 only in state IDLE. A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1.
REQ-020 States SHALL be IDLE, FILL, COPY and COPY_DRAIN. No other states exist.
REQ-021 select SHALL set work_page to the resolved arg0 at the accept edge. done SHALL be 1 in the following cycle. The state SHALL remain IDLE.
REQ-022 blit SHALL act at the accept edge as follows: arg0=0xFE -> no change; arg0=0xFF -> front_page and back_page swap; otherwise front_page = arg0[1:0]. done SHALL be 1 in the following cycle.
REQ-023 fill SHALL enter FILL and perform WORDS consecutive write cycles, one per clock. Write cycle i SHALL drive vram_we=1, vram_waddr={page, i}, vram_wdata={c,c,c,c} with c=arg1[3:0].
REQ-024 After the last fill write edge, the state SHALL be IDLE and done SHALL be 1 for one cycle. Total busy time SHALL be WORDS cycles.
REQ-025 copy SHALL enter COPY. In cycle k (k=0..WORDS-1) it SHALL drive vram_re=1, vram_raddr={src, k}.
REQ-026 In cycle k+1, copy SHALL drive vram_we=1, vram_waddr={dst, k}, vram_wdata=vram_rdata. Throughput SHALL be 1 word/clk.
REQ-027 Cycle WORDS of a copy SHALL be COPY_DRAIN: final write only, vram_re=0. Total busy time SHALL be WORDS+1 cycles, then IDLE with done=1 for one cycle.
REQ-028 A copy with src equal to dst SHALL execute normally (every word rewritten with its own value).
REQ-029 The word counter SHALL be 14 bits and SHALL stop at WORDS-1; it SHALL never wrap into the next page.
REQ-030 busy SHALL be 1 in FILL, COPY and COPY_DRAIN, and 0 otherwise. vram_we and vram_re SHALL be 0 in IDLE.
REQ-031 cmd_* inputs SHALL be ignored while busy. The page registers SHALL change only through select or blit.
REQ-032 done and the next accept SHALL be able to coincide: the block is ready in the same cycle that done is 1.

Reset
REQ-033 While reset=1 the block SHALL hold: state IDLE, counter 0, work_page=2, front_page=2, back_page=1, busy=0, done=0, vram_we=0, vram_re=0, addresses and wdata=0.
REQ-034 Reset asserted mid-fill or mid-copy SHALL abort the operation immediately and asynchronously. No further writes SHALL occur; no done pulse SHALL be produced.

Verification
REQ-035 With WORDS=8: fill, arg0=0x01, arg1=0x5 -> 8 cycles of vram_we with waddr 0x4000..0x4007 and wdata 0x5555; then done pulse; busy for exactly 8 cycles.
REQ-036 With WORDS=8 and vram model rdata=raddr: copy, arg0=0, arg1=3 -> writes to 0xC000..0xC007 with data 0x0000..0x0007, each one cycle after its read; busy for 9 cycles.
REQ-037 After reset: blit 0xFF -> front=1, back=2; blit 0xFE -> unchanged; blit 0x03 -> front=3; then select 0xFE -> work=3.
REQ-038 Fill with arg0=0xFF after reset -> writes go to page 1 (0x4000 base); a command held valid during busy is accepted only in the done cycle.
REQ-039 Reset pulse asserted at the 4th fill write -> vram_we=0 in the same cycle; outputs match the REQ-033 values; no done pulse.
